bellman_ford_engine: RTL and testbench

Parametrised single-source shortest-path engine. It runs Bellman-Ford relaxation over an external, read-only edge list and keeps vertex distance and predecessor arrays internally. It exits early once a pass makes no update, and runs one extra check pass to flag negative cycles. It sits between the graph loader (edge memory) and the path-trace/output writer, which reads results through the query port after `done`.

---
 rtl/bellman_ford_engine.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_bellman_ford_engine.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bellman_ford_engine.sv
// Single-source shortest-path engine: Bellman-Ford relaxation over an external
// edge list with early exit, a final check pass for negative cycles and a
// registered query port onto the internal distance / predecessor arrays.
module bellman_ford_engine #(
    parameter int VW = 6,
    parameter int DW = 16,
    parameter int EW = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [VW-1:0] source,
    input  logic [VW:0]   num_vertices,
    input  logic [EW:0]   num_edges,
    output logic          edge_rd,
    output logic [EW-1:0] edge_addr,
    input  logic [VW-1:0] edge_src,
    input  logic [VW-1:0] edge_dst,
    input  logic [DW-1:0] edge_wt,
    output logic          busy,
    output logic          done,
    output logic          neg_cycle,
    output logic          err,
    output logic [VW:0]   passes,
    input  logic [VW-1:0] q_vertex,
    output logic [DW-1:0] q_dist,
    output logic [VW-1:0] q_prev
);

    localparam logic [DW-1:0]        INF       = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        ZERO_D    = {DW{1'b0}};
    localparam logic signed [DW:0]   CAND_MAX  = {2'b00, {(DW-2){1'b1}}, 1'b0};
    localparam logic signed [DW:0]   CAND_MIN  = {2'b11, {(DW-1){1'b0}}};
    localparam logic [VW:0]          ONE_V     = {{VW{1'b0}}, 1'b1};
    localparam logic [VW:0]          ZERO_V    = {(VW+1){1'b0}};
    localparam logic [VW:0]          V_CAP     = {1'b1, {VW{1'b0}}};
    localparam logic [EW:0]          ONE_E     = {{EW{1'b0}}, 1'b1};
    localparam logic [EW:0]          ZERO_E    = {(EW+1){1'b0}};
    localparam logic [VW-1:0]        VIDX_ONE  = {{(VW-1){1'b0}}, 1'b1};
    localparam logic [VW-1:0]        VIDX_ZERO = {VW{1'b0}};
    localparam logic [EW-1:0]        EIDX_ONE  = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]        EIDX_ZERO = {EW{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT     = 3'd1,
        S_FETCH    = 3'd2,
        S_RELAX    = 3'd3,
        S_PASS_END = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    // Signed add of distance and weight at DW+1 bits, clamped so a finite
    // result never collides with INF and never wraps below the minimum.
    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [DW:0] sum;
        sum = $signed({a[DW-1], a}) + $signed({b[DW-1], b});
        if (sum > CAND_MAX) begin
            sat_add = CAND_MAX[DW-1:0];
        end else if (sum < CAND_MIN) begin
            sat_add = CAND_MIN[DW-1:0];
        end else begin
            sat_add = sum[DW-1:0];
        end
    endfunction

    logic [DW-1:0] dist_mem [0:(1<<VW)-1];
    logic [VW-1:0] prev_mem [0:(1<<VW)-1];

    state_t        state_r, state_s;
    logic [VW-1:0] src_r, src_s;
    logic [VW:0]   nv_r, nv_s;
    logic [EW:0]   ne_r, ne_s;
    logic [VW-1:0] v_r, v_s;
    logic [EW-1:0] e_r, e_s;
    logic          upd_r, upd_s;
    logic          check_r, check_s;
    logic [VW:0]   passes_r, passes_s;
    logic          neg_r, neg_s;
    logic          err_r, err_s;
    logic          done_r, busy_r, edge_rd_r;
    logic [EW-1:0] edge_addr_r;
    logic [DW-1:0] q_dist_r;
    logic [VW-1:0] q_prev_r;

    logic          wr_en_s;
    logic [VW-1:0] wr_addr_s;
    logic [DW-1:0] wr_dist_s;
    logic [VW-1:0] wr_prev_s;
    logic [DW-1:0] d_src_s, d_dst_s, cand_s;
    logic          edge_ok_s, better_s, bad_cfg_s;

    // Configuration sanity: empty graph, source outside the graph, or more
    // vertices than the internal arrays can hold.
    always_comb begin
        bad_cfg_s = (num_vertices == ZERO_V) ||
                    ({1'b0, source} >= num_vertices) ||
                    (num_vertices > V_CAP);
    end

    // Relaxation datapath for the edge presented in RELAX.
    always_comb begin
        d_src_s   = dist_mem[edge_src];
        d_dst_s   = dist_mem[edge_dst];
        cand_s    = sat_add(d_src_s, edge_wt);
        edge_ok_s = ({1'b0, edge_src} < nv_r) && ({1'b0, edge_dst} < nv_r);
        better_s  = edge_ok_s && (d_src_s != INF) && ($signed(cand_s) < $signed(d_dst_s));
    end

    // Next-state and next-register logic for the control FSM.
    always_comb begin
        state_s   = state_r;
        src_s     = src_r;
        nv_s      = nv_r;
        ne_s      = ne_r;
        v_s       = v_r;
        e_s       = e_r;
        upd_s     = upd_r;
        check_s   = check_r;
        passes_s  = passes_r;
        neg_s     = neg_r;
        err_s     = err_r;
        wr_en_s   = 1'b0;
        wr_addr_s = v_r;
        wr_dist_s = INF;
        wr_prev_s = v_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    src_s    = source;
                    nv_s     = num_vertices;
                    ne_s     = num_edges;
                    neg_s    = 1'b0;
                    passes_s = ZERO_V;
                    v_s      = VIDX_ZERO;
                    e_s      = EIDX_ZERO;
                    upd_s    = 1'b0;
                    // A single vertex has no normal passes to run.
                    check_s  = (num_vertices == ONE_V);
                    if (bad_cfg_s) begin
                        err_s   = 1'b1;
                        state_s = S_DONE;
                    end else begin
                        err_s   = 1'b0;
                        state_s = S_INIT;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_INIT: begin
                wr_en_s   = 1'b1;
                wr_addr_s = v_r;
                wr_dist_s = (v_r == src_r) ? ZERO_D : INF;
                wr_prev_s = v_r;
                if (({1'b0, v_r} + ONE_V) == nv_r) begin
                    e_s     = EIDX_ZERO;
                    state_s = (ne_r == ZERO_E) ? S_PASS_END : S_FETCH;
                end else begin
                    v_s     = v_r + VIDX_ONE;
                    state_s = S_INIT;
                end
            end
            S_FETCH: begin
                state_s = S_RELAX;
            end
            S_RELAX: begin
                if (better_s) begin
                    upd_s = 1'b1;
                    if (!check_r) begin
                        wr_en_s   = 1'b1;
                        wr_addr_s = edge_dst;
                        wr_dist_s = cand_s;
                        wr_prev_s = edge_src;
                    end else begin
                        wr_en_s   = 1'b0;
                    end
                end else begin
                    upd_s = upd_r;
                end
                if (({1'b0, e_r} + ONE_E) < ne_r) begin
                    e_s     = e_r + EIDX_ONE;
                    state_s = S_FETCH;
                end else begin
                    state_s = S_PASS_END;
                end
            end
            S_PASS_END: begin
                passes_s = passes_r + ONE_V;
                upd_s    = 1'b0;
                e_s      = EIDX_ZERO;
                if (check_r) begin
                    neg_s   = upd_r;
                    state_s = S_DONE;
                end else if (!upd_r) begin
                    state_s = S_DONE;
                end else begin
                    // Only normal passes precede the check pass, so the
                    // pass count equals the normal-pass count here.
                    if (passes_s == (nv_r - ONE_V)) begin
                        check_s = 1'b1;
                    end else begin
                        check_s = 1'b0;
                    end
                    state_s = (ne_r == ZERO_E) ? S_PASS_END : S_FETCH;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Control registers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            src_r       <= VIDX_ZERO;
            nv_r        <= ZERO_V;
            ne_r        <= ZERO_E;
            v_r         <= VIDX_ZERO;
            e_r         <= EIDX_ZERO;
            upd_r       <= 1'b0;
            check_r     <= 1'b0;
            passes_r    <= ZERO_V;
            neg_r       <= 1'b0;
            err_r       <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            edge_rd_r   <= 1'b0;
            edge_addr_r <= EIDX_ZERO;
        end else begin
            state_r     <= state_s;
            src_r       <= src_s;
            nv_r        <= nv_s;
            ne_r        <= ne_s;
            v_r         <= v_s;
            e_r         <= e_s;
            upd_r       <= upd_s;
            check_r     <= check_s;
            passes_r    <= passes_s;
            neg_r       <= neg_s;
            err_r       <= err_s;
            done_r      <= (state_s == S_DONE);
            busy_r      <= (state_s != S_IDLE);
            edge_rd_r   <= (state_s == S_FETCH);
            edge_addr_r <= e_s;
        end
    end

    // Distance / predecessor arrays; contents intentionally not reset.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            dist_mem[wr_addr_s] <= wr_dist_s;
            prev_mem[wr_addr_s] <= wr_prev_s;
        end
    end

    // Registered query port; holds its last value while a run is active.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_dist_r <= ZERO_D;
            q_prev_r <= VIDX_ZERO;
        end else if (!busy_r) begin
            q_dist_r <= dist_mem[q_vertex];
            q_prev_r <= prev_mem[q_vertex];
        end else begin
            q_dist_r <= q_dist_r;
            q_prev_r <= q_prev_r;
        end
    end

    assign edge_rd   = edge_rd_r;
    assign edge_addr = edge_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign neg_cycle = neg_r;
    assign err       = err_r;
    assign passes    = passes_r;
    assign q_dist    = q_dist_r;
    assign q_prev    = q_prev_r;

endmodule

// File: tb/tb_bellman_ford_engine.sv
// Scoreboard bench for bellman_ford_engine: a plain Bellman-Ford reference
// model predicts each run; a monitor compares completions and query results.
module tb_bellman_ford_engine;

    localparam int VW = 6;
    localparam int DW = 16;
    localparam int EW = 10;

    logic          clock;
    logic          reset;
    logic          start;
    logic [VW-1:0] source;
    logic [VW:0]   num_vertices;
    logic [EW:0]   num_edges;
    logic          edge_rd;
    logic [EW-1:0] edge_addr;
    logic [VW-1:0] edge_src;
    logic [VW-1:0] edge_dst;
    logic [DW-1:0] edge_wt;
    logic          busy;
    logic          done;
    logic          neg_cycle;
    logic          err;
    logic [VW:0]   passes;
    logic [VW-1:0] q_vertex;
    logic [DW-1:0] q_dist;
    logic [VW-1:0] q_prev;

    bellman_ford_engine #(.VW(VW), .DW(DW), .EW(EW)) dut (
        .clock(clock), .reset(reset), .start(start), .source(source),
        .num_vertices(num_vertices), .num_edges(num_edges),
        .edge_rd(edge_rd), .edge_addr(edge_addr),
        .edge_src(edge_src), .edge_dst(edge_dst), .edge_wt(edge_wt),
        .busy(busy), .done(done), .neg_cycle(neg_cycle), .err(err),
        .passes(passes), .q_vertex(q_vertex), .q_dist(q_dist), .q_prev(q_prev)
    );

    typedef struct {
        int passes;
        int neg;
        int err;
        int lat;
        int k;
    } run_t;

    typedef struct {
        int d;
        int p;
    } qexp_t;

    run_t  rq[$];
    qexp_t qq[$];

    logic [VW-1:0] m_src [1024];
    logic [VW-1:0] m_dst [1024];
    logic [DW-1:0] m_wt  [1024];
    int exp_d [64];
    int exp_p [64];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Edge memory: data follows the read strobe by one cycle.
    always @(posedge clock) begin
        if (edge_rd) begin
            edge_src <= m_src[edge_addr];
            edge_dst <= m_dst[edge_addr];
            edge_wt  <= m_wt[edge_addr];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_edge(input int i, input int s, input int d, input int w);
        m_src[i] = s[VW-1:0];
        m_dst[i] = d[VW-1:0];
        m_wt[i]  = w[DW-1:0];
    endtask

    // Reference model: textbook Bellman-Ford in edge-list order, saturating
    // sums, early exit and one extra non-writing detection pass.
    task automatic model(input int V, input int src, input int E, output run_t r);
        int d [64];
        int p [64];
        int upd, chk_pass, s, t, w, c;
        r.k = 0; r.neg = 0; r.passes = 0; r.err = 0; r.lat = 1;
        if (V == 0 || src >= V || V > 64) begin
            r.err = 1;
            return;
        end
        for (int v = 0; v < V; v++) begin
            d[v] = (v == src) ? 0 : 32767;
            p[v] = v;
        end
        chk_pass = (V == 1) ? 1 : 0;
        while (1) begin
            upd = 0;
            for (int e = 0; e < E; e++) begin
                s = int'(m_src[e]);
                t = int'(m_dst[e]);
                w = int'($signed(m_wt[e]));
                if (s < V && t < V && d[s] != 32767) begin
                    c = d[s] + w;
                    if (c > 32766) c = 32766;
                    if (c < -32768) c = -32768;
                    if (c < d[t]) begin
                        upd = 1;
                        if (chk_pass == 0) begin
                            d[t] = c;
                            p[t] = s;
                        end
                    end
                end
            end
            r.passes++;
            if (chk_pass != 0) begin
                r.neg = upd;
                break;
            end
            if (upd == 0) break;
            if (r.passes == V - 1) chk_pass = 1;
        end
        r.lat = V + r.passes * (2 * E + 1) + 1;
        for (int v = 0; v < V; v++) begin
            exp_d[v] = d[v];
            exp_p[v] = p[v];
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_neg", int'(neg_cycle), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_edge_rd", int'(edge_rd), 0);
        chk("rst_edge_addr", int'(edge_addr), 0);
        chk("rst_passes", int'(passes), 0);
        chk("rst_q_dist", int'(q_dist), 0);
        chk("rst_q_prev", int'(q_prev), 0);
    endtask

    // One run: predict, start, optionally poke start mid-run, wait for done,
    // then read every vertex back through the query port.
    task automatic do_run(input int V, input int src, input int E, input bit poke);
        run_t r;
        int   t;
        model(V, src, E, r);
        @(negedge clock);
        num_vertices = V[VW:0];
        source       = src[VW-1:0];
        num_edges    = E[EW:0];
        start        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        r.k   = cyc;
        rq.push_back(r);
        if (poke) begin
            repeat (3) @(negedge clock);
            start        = 1'b1;
            num_vertices = {(VW+1){1'b0}};
            source       = source + 6'd1;
            @(negedge clock);
            start = 1'b0;
        end
        t = 0;
        while (done !== 1'b1 && t < 5000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 5000) begin
            chk("done_timeout", 0, 1);
            rq.delete();
        end
        @(posedge clock);
        #1;
        if (r.err == 0) begin
            for (int v = 0; v < V; v++) begin
                qexp_t qe;
                @(negedge clock);
                q_vertex = v[VW-1:0];
                @(posedge clock);
                #1;
                qe.d = exp_d[v];
                qe.p = exp_p[v];
                qq.push_back(qe);
            end
            @(negedge clock);
        end
    endtask

    // Monitor: compare each completion and each query result in order.
    always @(negedge clock) begin
        if (reset && done) begin
            if (rq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                run_t r;
                r = rq.pop_front();
                chk("passes", int'(passes), r.passes);
                chk("neg_cycle", int'(neg_cycle), r.neg);
                chk("err", int'(err), r.err);
                chk("latency", cyc - r.k + 1, r.lat);
            end
        end
        if (qq.size() > 0) begin
            qexp_t qe;
            qe = qq.pop_front();
            chk("q_dist", int'($signed(q_dist)), qe.d);
            chk("q_prev", int'(q_prev), qe.p);
        end
    end

    initial begin
        int V, src, E, w;
        reset        = 1'b0;
        start        = 1'b0;
        source       = '0;
        num_vertices = '0;
        num_edges    = '0;
        q_vertex     = '0;
        edge_src     = '0;
        edge_dst     = '0;
        edge_wt      = '0;
        repeat (2) @(negedge clock);
        check_reset_outputs();
        reset = 1'b1;

        // Chain with early exit.
        set_edge(0, 0, 1, 5);
        set_edge(1, 1, 2, -2);
        set_edge(2, 0, 2, 4);
        set_edge(3, 2, 3, 1);
        do_run(4, 0, 4, 1'b0);

        // Negative cycle reachable from the source.
        set_edge(0, 0, 1, 1);
        set_edge(1, 1, 2, -3);
        set_edge(2, 2, 1, 1);
        do_run(3, 0, 3, 1'b0);

        // Unreachable vertex keeps INF and itself as predecessor.
        set_edge(0, 0, 1, 7);
        do_run(3, 0, 1, 1'b0);

        // Configuration error and single vertex without edges.
        do_run(4, 5, 0, 1'b0);
        do_run(1, 0, 0, 1'b0);

        // Saturation at both ends of the range.
        set_edge(0, 0, 1, 32767);
        set_edge(1, 1, 2, 32767);
        do_run(3, 0, 2, 1'b0);
        set_edge(0, 0, 1, -32767);
        set_edge(1, 1, 2, -32767);
        do_run(3, 0, 2, 1'b0);

        // Start pulsed mid-run must be ignored.
        set_edge(0, 0, 1, 5);
        set_edge(1, 1, 2, -2);
        set_edge(2, 0, 2, 4);
        set_edge(3, 2, 3, 1);
        do_run(4, 0, 4, 1'b1);

        // Reset asserted mid-pass, then a normal run.
        @(negedge clock);
        num_vertices = 7'd4;
        source       = 6'd0;
        num_edges    = 11'd4;
        start        = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clock);
        reset = 1'b1;
        do_run(4, 0, 4, 1'b0);

        // Randomized graphs.
        for (int n = 0; n < 25; n++) begin
            V = int'($urandom_range(12, 1));
            src = ($urandom_range(15, 0) == 0) ? V + 1 : int'($urandom_range(V - 1, 0));
            E = int'($urandom_range(24, 0));
            for (int i = 0; i < E; i++) begin
                if ($urandom_range(9, 0) == 0) begin
                    w = ($urandom_range(1, 0) == 0) ? 32767 : -32767;
                end else begin
                    w = int'($urandom_range(60, 0)) - 15;
                end
                set_edge(i, int'($urandom_range(V, 0)), int'($urandom_range(V, 0)), w);
            end
            do_run(V, src, E, 1'b0);
        end

        repeat (5) @(negedge clock);
        if (rq.size() != 0 || qq.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL pending_expectations: got %0d left expected 0", rq.size() + qq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
